uart_tx_sched: RTL and testbench

Round-robin transmit scheduler that shares the single `uart_tx` instance between `NREQ` byte producers. Each requester offers bytes on a valid/ready handshake. The scheduler picks a winner, latches its byte and issues a one-cycle start to the transmitter. It tracks frame completion by counting `tx_br_stb` baud strobes, and enforces an optional idle gap between frames. It sits between the requester logic and `uart_tx` inside `uart_top`, on the same `baudrate_gen` TX strobe.

---
 rtl/uart_tx_sched_pkg.sv | 15 +
 rtl/uart_tx_sched_rr_pick.sv | 32 +++
 rtl/uart_tx_sched.sv | 104 ++++++++++
 tb/tb_uart_tx_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: state encodings,
// byte width, default frame length and bit counter width.
package uart_tx_sched_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_FRAME_BITS = 10;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping
// modulo NREQ, and returns the first set bit as a one-hot grant plus index.
module uart_rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id
);

    // Walk from the farthest slot back towards ptr so the nearest hit wins last
    always_comb begin
        int idx;
        gnt    = '0;
        gnt_id = '0;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte
// producers; tracks frame and optional idle gap by counting baud strobes.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int GAP_BITS   = 0,
    localparam int ID_W      = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [BYTE_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     tx_br_stb,
    output logic                     tx_start,
    output logic [BYTE_W-1:0]        tx_data,
    output logic                     tx_busy,
    output logic [ID_W-1:0]          grant_id
);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_BITS - 1);
    localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NREQ - 1);

    sched_state_t      state;
    sched_state_t      next_state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ID_W-1:0]   rr_ptr;
    logic [NREQ-1:0]   pick_gnt;
    logic [ID_W-1:0]   pick_id;
    logic              xfer;
    logic              counting;
    logic              bit_last;

    uart_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (pick_gnt),
        .gnt_id (pick_id)
    );

    // Ready is only offered while idle; reset masks it so a held request sees nothing
    assign req_ready = (state == IDLE && !rst) ? pick_gnt : '0;
    assign xfer      = (state == IDLE) && (|pick_gnt);
    assign counting  = (state == SEND || state == GAP) && tx_br_stb;
    assign bit_last  = counting &&
                       ((state == SEND && bit_cnt == FRAME_LAST) ||
                        (state == GAP  && bit_cnt == GAP_LAST));
    assign tx_busy   = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: idle until a handshake, then frame, then optional gap
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (xfer)     next_state = SEND;
            SEND: if (bit_last) next_state = (GAP_BITS > 0) ? GAP : IDLE;
            GAP:  if (bit_last) next_state = IDLE;
            default:            next_state = IDLE;
        endcase
    end

    // Bit period counter, shared by the frame and the gap phases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (bit_last) begin
            bit_cnt <= '0;
        end else if (counting) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Latch the winner's byte and id on the handshake and advance the pointer past it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            tx_start <= xfer;
            if (xfer) begin
                tx_data  <= req_data[int'(pick_id)*BYTE_W +: BYTE_W];
                grant_id <= pick_id;
                rr_ptr   <= (pick_id == LAST_ID) ? '0 : pick_id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched: one instance without gap, one with
// a two-bit idle gap, driven by a linear sequence of hand-computed steps.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;

    logic [3:0]  valid0;
    logic [31:0] data0;
    logic [3:0]  ready0;
    logic        start0;
    logic [7:0]  txd0;
    logic        busy0;
    logic [1:0]  gid0;

    logic [3:0]  valid1;
    logic [31:0] data1;
    logic [3:0]  ready1;
    logic        start1;
    logic [7:0]  txd1;
    logic        busy1;
    logic [1:0]  gid1;

    int total = 0;
    int bad   = 0;

    uart_tx_sched #(.NREQ(4), .FRAME_BITS(10), .GAP_BITS(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (valid0),
        .req_data  (data0),
        .req_ready (ready0),
        .tx_br_stb (stb),
        .tx_start  (start0),
        .tx_data   (txd0),
        .tx_busy   (busy0),
        .grant_id  (gid0)
    );

    uart_tx_sched #(.NREQ(4), .FRAME_BITS(10), .GAP_BITS(2)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (valid1),
        .req_data  (data1),
        .req_ready (ready1),
        .tx_br_stb (stb),
        .tx_start  (start1),
        .tx_data   (txd1),
        .tx_busy   (busy1),
        .grant_id  (gid1)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_stb();
        stb = 1'b1;
        tick();
        stb = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Hard stop in case a step never returns
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus sequence
    initial begin
        int  n_stb;
        int  n_low;
        bit  seen;

        rst    = 1'b1;
        stb    = 1'b0;
        valid0 = '0;
        data0  = '0;
        valid1 = '0;
        data1  = '0;

        tick();
        tick();
        check_output("rst ready",  ready0, 4'b0000);
        check_output("rst start",  start0, 1'b0);
        check_output("rst busy",   busy0,  1'b0);
        check_output("rst data",   txd0,   8'h00);
        check_output("rst gid",    gid0,   2'd0);
        check_output("rst busy1",  busy1,  1'b0);
        rst = 1'b0;
        tick();

        $display("[TB] all four requesters held");
        valid0 = 4'b1111;
        data0  = 32'h13121110;
        #1;
        check_output("rr first ready", ready0, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("rr start", start0, 1'b1);
            check_output("rr gid",   gid0,   i % 4);
            check_output("rr data",  txd0,   8'h10 + (i % 4));
            check_output("rr busy",  busy0,  1'b1);
            if (i == 4) valid0 = 4'b0000;
            stb = 1'b1;
            repeat (10) tick();
            stb = 1'b0;
            check_output("rr end busy",  busy0,  1'b0);
            check_output("rr end start", start0, 1'b0);
            if (i < 4) check_output("rr next ready", ready0, 4'b0001 << ((i + 1) % 4));
            else       check_output("rr drained ready", ready0, 4'b0000);
        end

        $display("[TB] single request on requester 2");
        valid0 = 4'b0100;
        data0  = 32'h00A50000;
        #1;
        check_output("single ready", ready0, 4'b0100);
        tick();
        valid0 = 4'b0000;
        #1;
        check_output("single start", start0, 1'b1);
        check_output("single data",  txd0,   8'hA5);
        check_output("single gid",   gid0,   2'd2);
        check_output("single busy",  busy0,  1'b1);
        check_output("single ready low", ready0, 4'b0000);
        pulse_stb();
        check_output("single start pulse", start0, 1'b0);
        repeat (8) begin
            tick();
            pulse_stb();
        end
        check_output("single busy at 9", busy0, 1'b1);
        tick();
        pulse_stb();
        check_output("single busy after 10", busy0, 1'b0);

        $display("[TB] pointer fairness");
        valid0 = 4'b1010;
        data0  = 32'h23002100;
        #1;
        check_output("fair ready", ready0, 4'b1000);
        tick();
        check_output("fair gid3",  gid0, 2'd3);
        check_output("fair data3", txd0, 8'h23);
        valid0 = 4'b0010;
        stb = 1'b1;
        repeat (10) tick();
        stb = 1'b0;
        check_output("fair busy", busy0, 1'b0);
        check_output("fair ready1", ready0, 4'b0010);
        tick();
        check_output("fair start1", start0, 1'b1);
        check_output("fair gid1",   gid0,   2'd1);
        check_output("fair data1",  txd0,   8'h21);
        valid0 = 4'b0000;
        stb = 1'b1;
        repeat (10) tick();
        stb = 1'b0;
        check_output("fair end busy", busy0, 1'b0);

        $display("[TB] strobe during handshake cycle");
        valid0 = 4'b0001;
        data0  = 32'h0000003C;
        stb    = 1'b1;
        #1;
        check_output("hs ready", ready0, 4'b0001);
        tick();
        stb    = 1'b0;
        valid0 = 4'b0000;
        check_output("hs start", start0, 1'b1);
        check_output("hs gid",   gid0,   2'd0);
        check_output("hs data",  txd0,   8'h3C);
        tick();
        repeat (8) begin
            pulse_stb();
            tick();
        end
        pulse_stb();
        check_output("hs busy after 9", busy0, 1'b1);
        tick();
        pulse_stb();
        check_output("hs busy after 10", busy0, 1'b0);

        $display("[TB] reset mid-frame");
        valid0 = 4'b0111;
        data0  = 32'h00AA775A;
        #1;
        check_output("mid ready", ready0, 4'b0010);
        tick();
        check_output("mid gid",  gid0, 2'd1);
        check_output("mid data", txd0, 8'h77);
        stb = 1'b1;
        repeat (5) tick();
        stb = 1'b0;
        check_output("mid busy", busy0, 1'b1);
        rst = 1'b1;
        #1;
        check_output("mid rst ready", ready0, 4'b0000);
        check_output("mid rst start", start0, 1'b0);
        check_output("mid rst busy",  busy0,  1'b0);
        check_output("mid rst data",  txd0,   8'h00);
        check_output("mid rst gid",   gid0,   2'd0);
        tick();
        check_output("mid rst held ready", ready0, 4'b0000);
        rst = 1'b0;
        #1;
        check_output("post rst ready", ready0, 4'b0001);
        tick();
        check_output("post rst start", start0, 1'b1);
        check_output("post rst gid",   gid0,   2'd0);
        check_output("post rst data",  txd0,   8'h5A);
        valid0 = 4'b0000;
        stb = 1'b1;
        repeat (10) tick();
        stb = 1'b0;
        check_output("post rst end busy", busy0, 1'b0);

        $display("[TB] two queued bytes with a two-bit gap");
        valid1 = 4'b0011;
        data1  = 32'h0000B2B1;
        #1;
        check_output("gap ready", ready1, 4'b0001);
        tick();
        check_output("gap start0", start1, 1'b1);
        check_output("gap gid0",   gid1,   2'd0);
        check_output("gap data0",  txd1,   8'hB1);
        valid1 = 4'b0010;
        n_stb  = 0;
        n_low  = 0;
        seen   = 1'b0;
        stb    = 1'b1;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (busy1) n_stb++;
            else       n_low++;
            tick();
            if (start1) seen = 1'b1;
        end
        check_output("gap second start seen", seen,  1'b1);
        check_output("gap strobes between",   n_stb, 12);
        check_output("gap idle cycles",       n_low, 1);
        check_output("gap gid1",  gid1, 2'd1);
        check_output("gap data1", txd1, 8'hB2);
        valid1 = 4'b0000;
        repeat (11) tick();
        check_output("gap busy before last", busy1, 1'b1);
        tick();
        stb = 1'b0;
        check_output("gap end busy", busy1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
